posit_add_sched: RTL and testbench
==================================

POSIT_ADD_SCHED -- requirements
Module: posit_add_sched

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters sharing one posit adder (2..8).
REQ-002 Parameter LATENCY, default 4, is the number of cycles from the adder sampling start=1 to done=1.
REQ-003 Parameter NBITS, default 32, is the posit width.
REQ-004 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, is an asynchronous active-low reset.
REQ-006 Port cfg_enable, input, 1, enables new grants when high.
REQ-007 Port req_valid, input, NREQ, carries per-requester operand valid.
REQ-008 Port req_ready, output, NREQ, is the per-requester accept strobe (one-hot or zero).
REQ-009 Port req_a and port req_b, input, NREQ*NBITS each, carry operands; slice i belongs to requester i.
REQ-010 Port add_start, output, 1, is the adder start.
REQ-011 Port add_in1 and port add_in2, output, NBITS each, are the adder operands.
REQ-012 Port add_result, input, NBITS, carries the adder result; add_inf and add_zero, input, 1 each, carry the adder flags; add_done, input, 1, is the adder done.
REQ-013 Port rsp_valid, output, NREQ, is the one-hot response strobe.
REQ-014 Port rsp_data, output, NBITS, carries the response result; rsp_inf and rsp_zero, output, 1 each, carry the response flags.
REQ-015 Port busy, output, 1, is high whenever state is not IDLE.
REQ-016 Port err_seq, output, 1, is a sticky done/tag mismatch flag.

Function
REQ-017 The block SHALL have three states: IDLE (enable low, nothing in flight), RUN (enable high), and DRAIN (enable low, operations in flight).
REQ-018 The block SHALL make these transitions: IDLE->RUN on cfg_enable=1; RUN->DRAIN on cfg_enable=0 with in-flight>0; RUN->IDLE on cfg_enable=0 with in-flight=0; DRAIN->RUN on cfg_enable=1; DRAIN->IDLE when in-flight reaches 0.
REQ-019 Grants SHALL be issued only in RUN, with at most one per cycle, and the grant SHALL be combinational: req_ready[i]=1 only for the winner, in the same cycle that req_valid[i]=1.
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on a grant; after reset last_grant=NREQ-1, so requester 0 has first priority.
REQ-021 On a grant, add_start SHALL be 1 and add_in1/add_in2 SHALL equal the winner's req_a/req_b in the same cycle; otherwise add_start SHALL be 0 and add_in1/add_in2 SHALL be 0.
REQ-022 A tag pipeline of LATENCY stages SHALL carry {valid, requester index}; stage 0 loads on every edge, and stage k loads from stage k-1.
REQ-023 The in-flight count SHALL equal the number of valid tag stages and SHALL never exceed LATENCY, so no other throttling is needed.
REQ-024 When the last tag stage is valid and add_done=1, rsp_valid[idx] SHALL be 1 for exactly that cycle, with rsp_data/rsp_inf/rsp_zero passed through combinationally from the adder.
REQ-025 When the last tag stage is valid and add_done=0, or when add_done=1 and the last tag stage is invalid, err_seq SHALL set and hold until reset, and no rsp_valid SHALL assert.
REQ-026 Responses SHALL have no backpressure; requesters must accept rsp_valid unconditionally.
REQ-027 The response for a grant in cycle t SHALL appear in cycle t+LATENCY.
REQ-028 The block SHALL not reorder: responses leave in grant order.
REQ-029 If cfg_enable falls in the same cycle as a request, that request SHALL not be granted (state RUN evaluates enable combinationally).
REQ-030 When all req_valid=0 in RUN, there SHALL be no grant and last_grant SHALL be unchanged.

Reset
REQ-031 While rst_n=0, the block SHALL be in state IDLE with all tag stages invalid, last_grant=NREQ-1, and err_seq=0.
REQ-032 While rst_n=0, req_ready=0, add_start=0, rsp_valid=0 and busy=0.
REQ-033 A reset mid-operation SHALL discard in-flight tags; adder dones that arrive after rst_n rises, with no valid tag, SHALL set err_seq, and software clears the adder before re-enabling.

Verification
REQ-034 Single request: enable=1, req_valid=0001, a=0x40000000 (1.0), b=0x40000000 -> req_ready=0001 in cycle t, and rsp_valid=0001 with rsp_data=0x48000000 (2.0) in cycle t+4.
REQ-035 Full contention: all four requesters hold req_valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, with responses in the same order 4 cycles later.
REQ-036 Drain: grant in cycles 0-2, then cfg_enable=0 in cycle 3 -> no grants from cycle 3; state DRAIN until the third response in cycle 6; then IDLE with busy=0 in cycle 7.
REQ-037 Sequence error: inject add_done=1 with the pipeline empty -> err_seq=1, rsp_valid=0, and err_seq holds until rst_n=0.
REQ-038 Reset mid-flight: assert rst_n=0 with 3 ops in flight -> all outputs 0 immediately (asynchronous), and no responses after release.
REQ-039 Zero/inf propagation: a=0x80000000 (NaR) plus any operand -> rsp_inf=1 and rsp_data=0x80000000 on the granted requester.

Source files
------------

// File: rtl/posit_add_sched.sv
// posit_add_sched: round-robin scheduler sharing one fixed-latency posit adder
// among NREQ requesters, with in-order tagged response routing.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_enable          permits new grants while high
//   req_valid[NREQ]     per-requester operand valid
//   req_ready[NREQ]     combinational one-hot grant (accept strobe)
//   req_a, req_b        packed operands, slice i = requester i
//   add_start           adder start, high on the grant cycle
//   add_in1, add_in2    winner's operands, zero when no grant
//   add_result, add_inf, add_zero, add_done   adder return path
//   rsp_valid[NREQ]     one-hot response strobe, no backpressure
//   rsp_data, rsp_inf, rsp_zero               response payload, zero when idle
//   busy                state is not IDLE
//   err_seq             sticky done/tag mismatch
module posit_add_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned NBITS   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*NBITS-1:0]   req_a,
  input  logic [NREQ*NBITS-1:0]   req_b,
  output logic                    add_start,
  output logic [NBITS-1:0]        add_in1,
  output logic [NBITS-1:0]        add_in2,
  input  logic [NBITS-1:0]        add_result,
  input  logic                    add_inf,
  input  logic                    add_zero,
  input  logic                    add_done,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NBITS-1:0]        rsp_data,
  output logic                    rsp_inf,
  output logic                    rsp_zero,
  output logic                    busy,
  output logic                    err_seq
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = $clog2(LATENCY + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [IDXW-1:0]    last_grant_q;
  logic [LATENCY-1:0] tag_vld_q;
  logic [IDXW-1:0]    tag_idx_q [LATENCY];
  logic               err_seq_q;

  logic               grant_en;
  logic               grant_found;
  logic [IDXW-1:0]    grant_idx;
  logic [NREQ-1:0]    grant_oh;
  int unsigned        cand;
  logic [IDXW-1:0]    cand_idx;

  logic [CNTW-1:0]    inflight_nxt;
  logic               pending;
  logic               tag_last_vld;
  logic [IDXW-1:0]    tag_last_idx;
  logic               rsp_fire;
  logic               seq_err_c;

  // Grants are only allowed in RUN and only while enable is still high this cycle,
  // so a request coinciding with enable falling is not accepted.
  assign grant_en = (state_q == ST_RUN) && cfg_enable;

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (grant_en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand     = (32'(last_grant_q) + 32'd1 + k) % NREQ;
        cand_idx = IDXW'(cand);
        if (!grant_found && req_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // One-hot grant vector.
  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_oh[i] = grant_found && (grant_idx == IDXW'(i));
    end
  end

  // Operand mux; the one-hot OR keeps the outputs at zero without a grant.
  always_comb begin
    add_in1 = '0;
    add_in2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        add_in1 = add_in1 | req_a[i*NBITS +: NBITS];
        add_in2 = add_in2 | req_b[i*NBITS +: NBITS];
      end
    end
  end

  assign req_ready = grant_oh;
  assign add_start = grant_found;

  // Last winner; unchanged on cycles without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDXW'(NREQ - 1);
    end else if (grant_found) begin
      last_grant_q <= grant_idx;
    end
  end

  // Tag pipeline tracks {valid, requester} alongside the adder's own latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= grant_found;
      tag_idx_q[0] <= grant_idx;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
    end
  end

  // Operations still in flight after this edge: every stage except the retiring
  // last one, plus a new grant. Bounded by LATENCY by construction.
  always_comb begin
    inflight_nxt = CNTW'(grant_found);
    for (int unsigned k = 0; k + 1 < LATENCY; k++) begin
      inflight_nxt = inflight_nxt + CNTW'(tag_vld_q[k]);
    end
  end

  assign pending = (inflight_nxt != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!cfg_enable) begin
          state_d = pending ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cfg_enable) begin
          state_d = ST_RUN;
        end else if (!pending) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // Response routing: the oldest tag pairs with the adder's done.
  assign tag_last_vld = tag_vld_q[LATENCY-1];
  assign tag_last_idx = tag_idx_q[LATENCY-1];
  assign rsp_fire     = tag_last_vld && add_done;
  assign seq_err_c    = tag_last_vld ^ add_done;

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid[i] = rsp_fire && (tag_last_idx == IDXW'(i));
    end
  end

  assign rsp_data = rsp_fire ? add_result : '0;
  assign rsp_inf  = rsp_fire && add_inf;
  assign rsp_zero = rsp_fire && add_zero;

  // Sticky sequence error: a done without a tag or a tag without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq_q <= 1'b0;
    end else if (seq_err_c) begin
      err_seq_q <= 1'b1;
    end
  end

  assign err_seq = err_seq_q;

endmodule

// File: tb/tb_posit_add_sched.sv
// Directed bench for posit_add_sched with a fixed-latency posit adder stand-in.
module tb_posit_add_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned NBITS   = 32;

  localparam logic [31:0] P_ZERO = 32'h0000_0000;
  localparam logic [31:0] P_ONE  = 32'h4000_0000;
  localparam logic [31:0] P_TWO  = 32'h4800_0000;
  localparam logic [31:0] P_THR  = 32'h4C00_0000;
  localparam logic [31:0] P_FOUR = 32'h5000_0000;
  localparam logic [31:0] P_NAR  = 32'h8000_0000;

  logic                  clk;
  logic                  rst_n;
  logic                  cfg_enable;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*NBITS-1:0] req_a;
  logic [NREQ*NBITS-1:0] req_b;
  logic                  add_start;
  logic [NBITS-1:0]      add_in1;
  logic [NBITS-1:0]      add_in2;
  logic [NBITS-1:0]      add_result;
  logic                  add_inf;
  logic                  add_zero;
  logic                  add_done;
  logic [NREQ-1:0]       rsp_valid;
  logic [NBITS-1:0]      rsp_data;
  logic                  rsp_inf;
  logic                  rsp_zero;
  logic                  busy;
  logic                  err_seq;
  logic                  inj_done;

  int n_checks;
  int n_errors;

  posit_add_sched #(.NREQ(NREQ), .LATENCY(LATENCY), .NBITS(NBITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_enable (cfg_enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_start  (add_start),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_result (add_result),
    .add_inf    (add_inf),
    .add_zero   (add_zero),
    .add_done   (add_done),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_inf    (rsp_inf),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .err_seq    (err_seq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Adder stand-in: knows only the operand pairs this bench uses.
  function automatic logic [33:0] padd(input logic [31:0] a, input logic [31:0] b);
    if (a == P_NAR || b == P_NAR)         return {1'b1, 1'b0, P_NAR};
    if (a == P_ZERO && b == P_ZERO)       return {1'b0, 1'b1, P_ZERO};
    if (a == P_ZERO)                      return {1'b0, 1'b0, b};
    if (b == P_ZERO)                      return {1'b0, 1'b0, a};
    if (a == P_ONE && b == P_ONE)         return {1'b0, 1'b0, P_TWO};
    if (a == P_TWO && b == P_TWO)         return {1'b0, 1'b0, P_FOUR};
    if ((a == P_ONE && b == P_TWO) || (a == P_TWO && b == P_ONE))
                                          return {1'b0, 1'b0, P_THR};
    return {1'b0, 1'b0, a ^ b};
  endfunction

  logic [LATENCY-1:0] m_vld;
  logic [33:0]        m_res [LATENCY];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      for (int k = 0; k < LATENCY; k++) m_res[k] <= '0;
    end else begin
      m_vld[0] <= add_start;
      m_res[0] <= padd(add_in1, add_in2);
      for (int k = 1; k < LATENCY; k++) begin
        m_vld[k] <= m_vld[k-1];
        m_res[k] <= m_res[k-1];
      end
    end
  end

  assign add_done   = m_vld[LATENCY-1] | inj_done;
  assign add_result = m_res[LATENCY-1][31:0];
  assign add_zero   = m_res[LATENCY-1][32];
  assign add_inf    = m_res[LATENCY-1][33];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*NBITS +: NBITS] = a;
    req_b[i*NBITS +: NBITS] = b;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    req_valid  = '0;
    inj_done   = 1'b0;
    req_a      = '0;
    req_b      = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0]     exp_data [NREQ];
  logic [NREQ-1:0] e_oh;
  logic [NREQ-1:0] seen;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b1;
    cfg_enable = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    inj_done   = 1'b0;
    exp_data[0] = P_TWO;
    exp_data[1] = P_FOUR;
    exp_data[2] = P_THR;
    exp_data[3] = P_ZERO;
    #2 rst_n = 1'b0;

    // Reset state, with a request pending to show nothing leaks through.
    cfg_enable = 1'b1;
    req_valid  = 4'hF;
    step();
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_start", 64'(add_start), 64'h0);
    check("rst_rsp",   64'(rsp_valid), 64'h0);
    check("rst_busy",  64'(busy),      64'h0);
    check("rst_err",   64'(err_seq),   64'h0);

    // Single request: 1.0 + 1.0 = 2.0 after LATENCY cycles.
    do_reset();
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'h0);
    cfg_enable = 1'b1;
    step();
    set_op(0, P_ONE, P_ONE);
    req_valid = 4'b0001;
    @(negedge clk);
    check("s_ready", 64'(req_ready), 64'h1);
    check("s_start", 64'(add_start), 64'h1);
    check("s_in1",   64'(add_in1),   64'(P_ONE));
    check("s_in2",   64'(add_in2),   64'(P_ONE));
    check("s_busy",  64'(busy),      64'h1);
    step();
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("s_noreq_ready", 64'(req_ready), 64'h0);
        check("s_noreq_start", 64'(add_start), 64'h0);
        check("s_noreq_in1",   64'(add_in1),   64'h0);
      end
      if (k < 4) begin
        check("s_early_rsp", 64'(rsp_valid), 64'h0);
      end else begin
        check("s_rsp",  64'(rsp_valid), 64'h1);
        check("s_data", 64'(rsp_data),  64'(P_TWO));
        check("s_inf",  64'(rsp_inf),   64'h0);
      end
      step();
    end
    check("s_err", 64'(err_seq), 64'h0);

    // Full contention: grants rotate 0..3 twice, responses follow in order.
    do_reset();
    cfg_enable = 1'b1;
    step();
    set_op(0, P_ONE,  P_ONE);
    set_op(1, P_TWO,  P_TWO);
    set_op(2, P_ONE,  P_TWO);
    set_op(3, P_ZERO, P_ZERO);
    req_valid = 4'hF;
    for (int j = 0; j < 12; j++) begin
      if (j == 8) req_valid = '0;
      @(negedge clk);
      e_oh = (j < 8) ? 4'(1 << (j % 4)) : 4'h0;
      check("c_ready", 64'(req_ready), 64'(e_oh));
      if (j >= 4) begin
        e_oh = 4'(1 << ((j - 4) % 4));
        check("c_rsp",  64'(rsp_valid), 64'(e_oh));
        check("c_data", 64'(rsp_data),  64'(exp_data[(j - 4) % 4]));
        check("c_zero", 64'(rsp_zero),  64'(((j - 4) % 4) == 3));
      end else begin
        check("c_rsp_none", 64'(rsp_valid), 64'h0);
      end
      step();
    end
    check("c_err", 64'(err_seq), 64'h0);

    // Drain: three grants, enable drops with requests still pending.
    do_reset();
    cfg_enable = 1'b1;
    step();
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) cfg_enable = 1'b0;
      @(negedge clk);
      e_oh = (c < 3) ? 4'(1 << c) : 4'h0;
      check("d_ready", 64'(req_ready), 64'(e_oh));
      check("d_busy",  64'(busy),      64'(c < 7));
      e_oh = (c >= 4 && c <= 6) ? 4'(1 << (c - 4)) : 4'h0;
      check("d_rsp",   64'(rsp_valid), 64'(e_oh));
      step();
    end
    check("d_err", 64'(err_seq), 64'h0);

    // Sequence error: stray done with an empty pipeline.
    do_reset();
    inj_done = 1'b1;
    @(negedge clk);
    check("e_rsp",  64'(rsp_valid), 64'h0);
    check("e_data", 64'(rsp_data),  64'h0);
    step();
    inj_done = 1'b0;
    @(negedge clk);
    check("e_set", 64'(err_seq), 64'h1);
    step();
    step();
    step();
    @(negedge clk);
    check("e_hold", 64'(err_seq), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("e_clear", 64'(err_seq), 64'h0);

    // Reset with three operations in flight.
    do_reset();
    cfg_enable = 1'b1;
    step();
    set_op(0, P_ONE, P_ONE);
    set_op(1, P_ONE, P_ONE);
    set_op(2, P_ONE, P_ONE);
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e_oh = 4'(1 << c);
      check("r_ready", 64'(req_ready), 64'(e_oh));
      step();
    end
    rst_n = 1'b0;
    #1;
    check("r_async_ready", 64'(req_ready), 64'h0);
    check("r_async_start", 64'(add_start), 64'h0);
    check("r_async_in1",   64'(add_in1),   64'h0);
    check("r_async_rsp",   64'(rsp_valid), 64'h0);
    check("r_async_busy",  64'(busy),      64'h0);
    cfg_enable = 1'b0;
    req_valid  = '0;
    step();
    step();
    rst_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
      step();
    end
    check("r_no_rsp", 64'(seen),    64'h0);
    check("r_err",    64'(err_seq), 64'h0);

    // NaR propagation on requester 2.
    do_reset();
    cfg_enable = 1'b1;
    step();
    set_op(2, P_NAR, P_ONE);
    req_valid = 4'b0100;
    @(negedge clk);
    check("n_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    step();
    step();
    step();
    @(negedge clk);
    check("n_rsp",  64'(rsp_valid), 64'h4);
    check("n_inf",  64'(rsp_inf),   64'h1);
    check("n_data", 64'(rsp_data),  64'(P_NAR));
    check("n_zero", 64'(rsp_zero),  64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
